// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl - load/store front-end for a single-port data SRAM.
//
// Turns byte/half/word requests at any byte address into one or two SRAM word
// accesses (active-low CSN/WEN, per-byte BE, 1-cycle registered read data),
// lane-aligns store data and enables, and sign/zero-extends load data.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   REQ_VALID/READY     request handshake (READY only while idle)
//   REQ_WE              1 = store, 0 = load
//   REQ_SIZE            00 byte, 01 half, 10 word, 11 illegal
//   REQ_UNSIGNED        load extension: 1 zero, 0 sign
//   REQ_ADDR            byte address (AWIDTH+2 bits, little-endian)
//   REQ_WDATA           right-justified store data
//   RSP_VALID           one-cycle completion pulse
//   RSP_RDATA           extended load data (0 for stores/errors)
//   RSP_ERR             illegal-size flag, valid with RSP_VALID
//   MEM_CSN/WEN/BE      SRAM controls
//   MEM_ADDR, MEM_DI    SRAM word address and write data
//   MEM_DOUT            SRAM read data, valid the cycle after its access edge
module dmem_lsu_ctrl #(
  parameter int unsigned AWIDTH = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_UNSIGNED,
  input  logic [AWIDTH+1:0] REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERR,
  output logic              MEM_CSN,
  output logic [AWIDTH-1:0] MEM_ADDR,
  output logic              MEM_WEN,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_DI,
  input  logic [31:0]       MEM_DOUT
);

  typedef enum logic [2:0] {S_IDLE, S_ACC1, S_ACC2, S_CAP, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic              split_q, split_d;
  logic [AWIDTH-1:0] wa_q, wa_d;
  logic [3:0]        be_hi_q, be_hi_d;
  logic [31:0]       di_hi_q, di_hi_d;
  logic [31:0]       w1_q, w1_d;

  logic              csn_q, csn_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       di_q, di_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  // request decode (used only on the accept edge)
  logic [2:0]        req_n;
  logic [31:0]       req_ws;
  logic [7:0]        req_m8;
  logic [63:0]       req_d64;
  logic              req_split;

  // load assembly
  logic [31:0]       ld_w1, ld_w2, ld_word, ld_ext;

  always_comb begin
    req_n  = 3'd4;
    req_ws = REQ_WDATA;
    req_m8 = 8'h0F;
    unique case (REQ_SIZE)
      2'b00: begin req_n = 3'd1; req_ws = {24'h0, REQ_WDATA[7:0]};  req_m8 = 8'h01; end
      2'b01: begin req_n = 3'd2; req_ws = {16'h0, REQ_WDATA[15:0]}; req_m8 = 8'h03; end
      default: ;
    endcase
    req_m8    = req_m8 << REQ_ADDR[1:0];
    req_d64   = {32'h0, req_ws} << {REQ_ADDR[1:0], 3'b000};
    req_split = ({1'b0, REQ_ADDR[1:0]} + req_n) > 3'd4;
  end

  // For a split load the first word was captured in w1_q and the second word is
  // on MEM_DOUT; otherwise MEM_DOUT holds the only word.
  always_comb begin
    ld_w1   = split_q ? w1_q : MEM_DOUT;
    ld_w2   = split_q ? MEM_DOUT : '0;
    ld_word = 32'({ld_w2, ld_w1} >> {off_q, 3'b000});
    ld_ext  = ld_word;
    unique case (size_q)
      2'b00:   ld_ext = uns_q ? {24'h0, ld_word[7:0]}  : {{24{ld_word[7]}},  ld_word[7:0]};
      2'b01:   ld_ext = uns_q ? {16'h0, ld_word[15:0]} : {{16{ld_word[15]}}, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    split_d     = split_q;
    wa_d        = wa_q;
    be_hi_d     = be_hi_q;
    di_hi_d     = di_hi_q;
    w1_d        = w1_q;
    csn_d       = csn_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    be_d        = be_q;
    di_d        = di_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          we_d        = REQ_WE;
          size_d      = REQ_SIZE;
          uns_d       = REQ_UNSIGNED;
          off_d       = REQ_ADDR[1:0];
          split_d     = req_split;
          wa_d        = REQ_ADDR[AWIDTH+1:2];
          be_hi_d     = req_m8[7:4];
          di_hi_d     = req_d64[63:32];
          rsp_rdata_d = '0;
          if (REQ_SIZE == 2'b11) begin
            rsp_err_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            rsp_err_d = 1'b0;
            csn_d     = 1'b0;
            addr_d    = REQ_ADDR[AWIDTH+1:2];
            wen_d     = ~REQ_WE;
            be_d      = REQ_WE ? req_m8[3:0]   : '0;
            di_d      = REQ_WE ? req_d64[31:0] : '0;
            state_d   = S_ACC1;
          end
        end
      end
      S_ACC1: begin
        if (split_q) begin
          addr_d  = AWIDTH'(wa_q + 1'b1);   // wraps to word 0 at the top
          be_d    = we_q ? be_hi_q : '0;
          di_d    = we_q ? di_hi_q : '0;
          state_d = S_ACC2;
        end else begin
          csn_d   = 1'b1;
          wen_d   = 1'b1;
          be_d    = '0;
          state_d = we_q ? S_RESP : S_CAP;
        end
      end
      S_ACC2: begin
        w1_d    = MEM_DOUT;
        csn_d   = 1'b1;
        wen_d   = 1'b1;
        be_d    = '0;
        state_d = we_q ? S_RESP : S_CAP;
      end
      S_CAP: begin
        rsp_rdata_d = ld_ext;
        state_d     = S_RESP;
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      off_q       <= '0;
      split_q     <= 1'b0;
      wa_q        <= '0;
      be_hi_q     <= '0;
      di_hi_q     <= '0;
      w1_q        <= '0;
      csn_q       <= 1'b1;
      addr_q      <= '0;
      wen_q       <= 1'b1;
      be_q        <= '0;
      di_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      split_q     <= split_d;
      wa_q        <= wa_d;
      be_hi_q     <= be_hi_d;
      di_hi_q     <= di_hi_d;
      w1_q        <= w1_d;
      csn_q       <= csn_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      be_q        <= be_d;
      di_q        <= di_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign REQ_READY = (state_q == S_IDLE);
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;
  assign MEM_CSN   = csn_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WEN   = wen_q;
  assign MEM_BE    = be_q;
  assign MEM_DI    = di_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed testbench for dmem_lsu_ctrl with a behavioural single-port SRAM.
module tb_dmem_lsu_ctrl;
  localparam int unsigned AW = 12;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ_VALID, REQ_READY, REQ_WE, REQ_UNSIGNED;
  logic [1:0]    REQ_SIZE;
  logic [AW+1:0] REQ_ADDR;
  logic [31:0]   REQ_WDATA;
  logic          RSP_VALID, RSP_ERR;
  logic [31:0]   RSP_RDATA;
  logic          MEM_CSN, MEM_WEN;
  logic [AW-1:0] MEM_ADDR;
  logic [3:0]    MEM_BE;
  logic [31:0]   MEM_DI, MEM_DOUT;

  always #5 CLK = ~CLK;

  dmem_lsu_ctrl #(.AWIDTH(AW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .MEM_CSN(MEM_CSN), .MEM_ADDR(MEM_ADDR), .MEM_WEN(MEM_WEN),
    .MEM_BE(MEM_BE), .MEM_DI(MEM_DI), .MEM_DOUT(MEM_DOUT)
  );

  // SRAM model: registered read, byte-masked write
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (!MEM_CSN) begin
      if (!MEM_WEN) begin
        for (int b = 0; b < 4; b++)
          if (MEM_BE[b]) mem[MEM_ADDR][8*b +: 8] <= MEM_DI[8*b +: 8];
      end else begin
        MEM_DOUT <= mem[MEM_ADDR];
      end
    end
  end

  // access log: {addr, write, be, di} for every edge with CSN low
  typedef logic [AW+36:0] acc_t;
  acc_t acc_q[$];
  always @(posedge CLK)
    if (MEM_CSN === 1'b0) acc_q.push_back({MEM_ADDR, ~MEM_WEN, MEM_BE, MEM_DI});

  int n_checks = 0;
  int n_fails  = 0;

  function automatic acc_t mk(input logic [AW-1:0] a, input logic w,
                              input logic [3:0] be, input logic [31:0] di);
    return {a, w, be, di};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_acc(input string tag, input int idx, input acc_t exp);
    logic [63:0] obs;
    obs = (idx < acc_q.size()) ? 64'(acc_q[idx]) : 64'hFFFF_FFFF_FFFF_FFFF;
    check(tag, obs, 64'(exp));
  endtask

  // Issue one request, scramble the request inputs after accept, and wait
  // (bounded) for RSP_VALID. lat = cycles from accept edge to RSP_VALID high.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [AW+1:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic err);
    acc_q.delete();
    check({tag, "_ready"}, 64'(REQ_READY), 64'd1);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = size; REQ_UNSIGNED = uns;
    REQ_ADDR = addr; REQ_WDATA = wd;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; REQ_WE = ~we; REQ_SIZE = 2'b11; REQ_UNSIGNED = ~uns;
    REQ_ADDR = ~addr; REQ_WDATA = ~wd;
    lat = 0;
    while (RSP_VALID !== 1'b1 && lat < 12) begin
      @(posedge CLK); #1;
      lat++;
    end
    rdata = RSP_RDATA;
    err   = RSP_ERR;
    @(posedge CLK); #1;
    check({tag, "_pulse"}, 64'(RSP_VALID), 64'd0);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  logic        seen;

  initial begin
    RST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_SIZE = 2'b00;
    REQ_UNSIGNED = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_csn",   64'(MEM_CSN),   64'd1);
    check("rst_wen",   64'(MEM_WEN),   64'd1);
    check("rst_be",    64'(MEM_BE),    64'd0);
    check("rst_addr",  64'(MEM_ADDR),  64'd0);
    check("rst_di",    64'(MEM_DI),    64'd0);
    check("rst_valid", 64'(RSP_VALID), 64'd0);
    check("rst_err",   64'(RSP_ERR),   64'd0);
    check("rst_rdata", 64'(RSP_RDATA), 64'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // aligned word store / load
    do_req("sw010", 1'b1, 2'b10, 1'b0, 14'h010, 32'hDEADBEEF, lat, rd, er);
    check("sw010_lat", 64'(lat), 64'd2);
    check("sw010_nacc", 64'(acc_q.size()), 64'd1);
    check_acc("sw010_acc0", 0, mk(12'h004, 1'b1, 4'hF, 32'hDEADBEEF));
    check("sw010_rdata", 64'(rd), 64'd0);
    check("sw010_err", 64'(er), 64'd0);
    do_req("lw010", 1'b0, 2'b10, 1'b0, 14'h010, 32'h0, lat, rd, er);
    check("lw010_lat", 64'(lat), 64'd3);
    check_acc("lw010_acc0", 0, mk(12'h004, 1'b0, 4'h0, 32'h0));
    check("lw010_rdata", 64'(rd), 64'hDEADBEEF);

    // byte store in top lane; upper wdata bits must be ignored
    do_req("sb013", 1'b1, 2'b00, 1'b0, 14'h013, 32'h12345680, lat, rd, er);
    check("sb013_lat", 64'(lat), 64'd2);
    check("sb013_nacc", 64'(acc_q.size()), 64'd1);
    check_acc("sb013_acc0", 0, mk(12'h004, 1'b1, 4'h8, 32'h80000000));
    do_req("lb013", 1'b0, 2'b00, 1'b0, 14'h013, 32'h0, lat, rd, er);
    check("lb013_lat", 64'(lat), 64'd3);
    check("lb013_rdata", 64'(rd), 64'hFFFFFF80);
    do_req("lbu013", 1'b0, 2'b00, 1'b1, 14'h013, 32'h0, lat, rd, er);
    check("lbu013_rdata", 64'(rd), 64'h00000080);
    // word 4 is now 0x80ADBEEF; half at offset 2 is 0x80AD
    do_req("lh012", 1'b0, 2'b01, 1'b0, 14'h012, 32'h0, lat, rd, er);
    check("lh012_lat", 64'(lat), 64'd3);
    check("lh012_rdata", 64'(rd), 64'hFFFF80AD);

    // illegal size directly after a load that left nonzero RDATA
    do_req("ill", 1'b0, 2'b11, 1'b0, 14'h010, 32'h0, lat, rd, er);
    check("ill_lat", 64'(lat), 64'd1);
    check("ill_nacc", 64'(acc_q.size()), 64'd0);
    check("ill_err", 64'(er), 64'd1);
    check("ill_rdata", 64'(rd), 64'd0);

    // split word store / load
    do_req("sw016", 1'b1, 2'b10, 1'b0, 14'h016, 32'h11223344, lat, rd, er);
    check("sw016_lat", 64'(lat), 64'd3);
    check("sw016_err", 64'(er), 64'd0);
    check("sw016_nacc", 64'(acc_q.size()), 64'd2);
    check_acc("sw016_acc0", 0, mk(12'h005, 1'b1, 4'hC, 32'h33440000));
    check_acc("sw016_acc1", 1, mk(12'h006, 1'b1, 4'h3, 32'h00001122));
    do_req("lw016", 1'b0, 2'b10, 1'b0, 14'h016, 32'h0, lat, rd, er);
    check("lw016_lat", 64'(lat), 64'd4);
    check_acc("lw016_acc1", 1, mk(12'h006, 1'b0, 4'h0, 32'h0));
    check("lw016_rdata", 64'(rd), 64'h11223344);

    // split half across the top of memory, wrapping to word 0
    do_req("sh3fff", 1'b1, 2'b01, 1'b0, 14'h3FFF, 32'hFFFFA5B6, lat, rd, er);
    check("sh3fff_lat", 64'(lat), 64'd3);
    check("sh3fff_nacc", 64'(acc_q.size()), 64'd2);
    check_acc("sh3fff_acc0", 0, mk(12'hFFF, 1'b1, 4'h8, 32'hB6000000));
    check_acc("sh3fff_acc1", 1, mk(12'h000, 1'b1, 4'h1, 32'h000000A5));
    do_req("lh3fff", 1'b0, 2'b01, 1'b0, 14'h3FFF, 32'h0, lat, rd, er);
    check("lh3fff_lat", 64'(lat), 64'd4);
    check("lh3fff_rdata", 64'(rd), 64'hFFFFA5B6);
    do_req("lhu3fff", 1'b0, 2'b01, 1'b1, 14'h3FFF, 32'h0, lat, rd, er);
    check("lhu3fff_rdata", 64'(rd), 64'h0000A5B6);

    // Reset during a split store: RST is sampled on the edge where access1 is
    // performed, so access1 lands, access2 is never issued, no response.
    do_req("pre5", 1'b1, 2'b10, 1'b0, 14'h014, 32'hAAAAAAAA, lat, rd, er);
    do_req("pre6", 1'b1, 2'b10, 1'b0, 14'h018, 32'hBBBBBBBB, lat, rd, er);
    acc_q.delete();
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'b10; REQ_UNSIGNED = 1'b0;
    REQ_ADDR = 14'h016; REQ_WDATA = 32'h55667788;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    check("rmid_csn1", 64'(MEM_CSN), 64'd0);
    check("rmid_be1", 64'(MEM_BE), 64'hC);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("rmid_csn",   64'(MEM_CSN),   64'd1);
    check("rmid_wen",   64'(MEM_WEN),   64'd1);
    check("rmid_be",    64'(MEM_BE),    64'd0);
    check("rmid_addr",  64'(MEM_ADDR),  64'd0);
    check("rmid_di",    64'(MEM_DI),    64'd0);
    check("rmid_ready", 64'(REQ_READY), 64'd1);
    seen = RSP_VALID;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      seen = seen | RSP_VALID;
    end
    check("rmid_norsp", 64'(seen), 64'd0);
    check("rmid_nacc", 64'(acc_q.size()), 64'd1);
    check_acc("rmid_acc0", 0, mk(12'h005, 1'b1, 4'hC, 32'h77880000));
    do_req("lw014", 1'b0, 2'b10, 1'b0, 14'h014, 32'h0, lat, rd, er);
    check("lw014_rdata", 64'(rd), 64'h7788AAAA);
    do_req("lw018", 1'b0, 2'b10, 1'b0, 14'h018, 32'h0, lat, rd, er);
    check("lw018_rdata", 64'(rd), 64'hBBBBBBBB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
